// File: rtl/sd_req_arbiter.sv
// Round-robin arbiter sharing one SPI-mode SD controller between the
// boot loader (port 0) and the disk DMA (port 1), with byte-count check.
module sd_req_arbiter #(
   parameter int BLK_BYTES     = 512,
   parameter int CNT_W         = 32,
   parameter int START_TIMEOUT = 64
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [1:0]  i_req,
   input  logic [1:0]  i_we,
   input  logic [31:0] i_blk_num0,
   input  logic [31:0] i_blk_num1,
   input  logic [31:0] i_adr0,
   input  logic [31:0] i_adr1,
   output logic [1:0]  o_grant,
   output logic [1:0]  o_done,
   output logic        o_err,
   output logic [7:0]  o_rdata,
   output logic [1:0]  o_rdata_en,
   input  logic [7:0]  i_wdata0,
   input  logic [7:0]  i_wdata1,
   output logic [1:0]  o_wdata_ready,
   input  logic        sd_ready,
   output logic        sd_ren,
   output logic        sd_wen,
   output logic [31:0] sd_blk_num,
   output logic [31:0] sd_adr,
   input  logic [7:0]  sd_rdata,
   input  logic        sd_rdata_en,
   output logic [7:0]  sd_wdata,
   input  logic        sd_wdata_ready
);

   typedef enum logic [2:0] {
      IDLE, ISSUE, WAIT_BUSY, BUSY, DONE
   } state_t;

   localparam int TMO_W = $clog2(START_TIMEOUT + 1);

   state_t             state_q, state_d;
   logic [1:0]         grant_q, grant_d;
   logic [1:0]         done_q, done_d;
   logic               err_q, err_d;
   logic [7:0]         rdata_q, rdata_d;
   logic [1:0]         rdata_en_q, rdata_en_d;
   logic               ren_q, ren_d;
   logic               wen_q, wen_d;
   logic [31:0]        blk_q, blk_d;
   logic [31:0]        adr_q, adr_d;
   logic               we_q, we_d;
   logic               gsel_q, gsel_d;
   logic               last_q, last_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [TMO_W-1:0]   tmo_q, tmo_d;

   logic               win;
   logic               sel_we;
   logic [31:0]        sel_blk;
   logic [31:0]        sel_adr;
   logic               step;
   logic [CNT_W-1:0]   exp_cnt;

   // expected byte total for the latched command, truncated to counter width
   assign exp_cnt = CNT_W'(blk_q) * CNT_W'(BLK_BYTES);

   // pick the winner: contested requests go to the port not served last
   always_comb begin
      win = i_req[1];
      if (i_req == 2'b11) win = ~last_q;
      sel_we  = i_we[win];
      sel_blk = win ? i_blk_num1 : i_blk_num0;
      sel_adr = win ? i_adr1 : i_adr0;
   end

   // next-state and registered-output logic of the transfer sequencer
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      done_d     = 2'b00;
      err_d      = err_q;
      rdata_d    = rdata_q;
      rdata_en_d = 2'b00;
      ren_d      = 1'b0;
      wen_d      = 1'b0;
      blk_d      = blk_q;
      adr_d      = adr_q;
      we_d       = we_q;
      gsel_d     = gsel_q;
      last_d     = last_q;
      cnt_d      = cnt_q;
      tmo_d      = tmo_q;
      step       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (sd_ready && (|i_req)) begin
               gsel_d  = win;
               grant_d = win ? 2'b10 : 2'b01;
               we_d    = sel_we;
               blk_d   = sel_blk;
               adr_d   = sel_adr;
               cnt_d   = '0;
               if (sel_blk == 32'd0) begin
                  state_d = DONE;
                  done_d  = win ? 2'b10 : 2'b01;
                  err_d   = 1'b1;
               end else begin
                  state_d = ISSUE;
                  ren_d   = ~sel_we;
                  wen_d   = sel_we;
               end
            end
         end
         ISSUE: begin
            state_d = WAIT_BUSY;
            tmo_d   = '0;
         end
         WAIT_BUSY: begin
            if (!sd_ready) begin
               state_d = BUSY;
            end else if (tmo_q == TMO_W'(START_TIMEOUT - 1)) begin
               state_d = DONE;
               done_d  = grant_q;
               err_d   = 1'b1;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         BUSY: begin
            if (we_q) begin
               step = sd_wdata_ready;
            end else begin
               step       = sd_rdata_en;
               rdata_d    = sd_rdata;
               rdata_en_d = sd_rdata_en ? grant_q : 2'b00;
            end
            if (step && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
            if (sd_ready) begin
               state_d = DONE;
               done_d  = grant_q;
               err_d   = (cnt_d != exp_cnt);
            end
         end
         DONE: begin
            state_d = IDLE;
            grant_d = 2'b00;
            err_d   = 1'b0;
            last_d  = gsel_q;
         end
         default: state_d = IDLE;
      endcase
   end

   // state and output registers; port 0 favoured out of reset
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= IDLE;
         grant_q    <= 2'b00;
         done_q     <= 2'b00;
         err_q      <= 1'b0;
         rdata_q    <= 8'd0;
         rdata_en_q <= 2'b00;
         ren_q      <= 1'b0;
         wen_q      <= 1'b0;
         blk_q      <= 32'd0;
         adr_q      <= 32'd0;
         we_q       <= 1'b0;
         gsel_q     <= 1'b0;
         last_q     <= 1'b1;
         cnt_q      <= '0;
         tmo_q      <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         done_q     <= done_d;
         err_q      <= err_d;
         rdata_q    <= rdata_d;
         rdata_en_q <= rdata_en_d;
         ren_q      <= ren_d;
         wen_q      <= wen_d;
         blk_q      <= blk_d;
         adr_q      <= adr_d;
         we_q       <= we_d;
         gsel_q     <= gsel_d;
         last_q     <= last_d;
         cnt_q      <= cnt_d;
         tmo_q      <= tmo_d;
      end
   end

   // write bytes pass straight through so the port can refill in time
   always_comb begin
      sd_wdata      = 8'd0;
      o_wdata_ready = 2'b00;
      if ((state_q == BUSY) && we_q) begin
         sd_wdata      = gsel_q ? i_wdata1 : i_wdata0;
         o_wdata_ready = sd_wdata_ready ? grant_q : 2'b00;
      end
   end

   assign o_grant    = grant_q;
   assign o_done     = done_q;
   assign o_err      = err_q;
   assign o_rdata    = rdata_q;
   assign o_rdata_en = rdata_en_q;
   assign sd_ren     = ren_q;
   assign sd_wen     = wen_q;
   assign sd_blk_num = blk_q;
   assign sd_adr     = adr_q;

endmodule

// File: tb/tb_sd_req_arbiter.sv
// Bench for sd_req_arbiter: table vectors, corner sequences and
// randomized transactions against a transaction-level reference.
module tb_sd_req_arbiter;

   localparam int BLK = 512;
   localparam int TMO = 64;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic [1:0]  i_req = 2'b00;
   logic [1:0]  i_we = 2'b00;
   logic [31:0] i_blk_num0 = '0;
   logic [31:0] i_blk_num1 = '0;
   logic [31:0] i_adr0 = '0;
   logic [31:0] i_adr1 = '0;
   logic [1:0]  o_grant, o_done, o_rdata_en, o_wdata_ready;
   logic        o_err;
   logic [7:0]  o_rdata;
   logic [7:0]  i_wdata0 = '0;
   logic [7:0]  i_wdata1 = '0;
   logic        sd_ready;
   logic        sd_ren, sd_wen;
   logic [31:0] sd_blk_num, sd_adr;
   logic [7:0]  sd_rdata;
   logic        sd_rdata_en;
   logic [7:0]  sd_wdata;
   logic        sd_wdata_ready;

   always #5 i_clk = ~i_clk;

   sd_req_arbiter #(
      .BLK_BYTES(BLK), .CNT_W(32), .START_TIMEOUT(TMO)
   ) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_req(i_req), .i_we(i_we),
      .i_blk_num0(i_blk_num0), .i_blk_num1(i_blk_num1),
      .i_adr0(i_adr0), .i_adr1(i_adr1),
      .o_grant(o_grant), .o_done(o_done), .o_err(o_err),
      .o_rdata(o_rdata), .o_rdata_en(o_rdata_en),
      .i_wdata0(i_wdata0), .i_wdata1(i_wdata1),
      .o_wdata_ready(o_wdata_ready),
      .sd_ready(sd_ready), .sd_ren(sd_ren), .sd_wen(sd_wen),
      .sd_blk_num(sd_blk_num), .sd_adr(sd_adr),
      .sd_rdata(sd_rdata), .sd_rdata_en(sd_rdata_en),
      .sd_wdata(sd_wdata), .sd_wdata_ready(sd_wdata_ready)
   );

   typedef struct {
      logic [1:0]  req;
      logic [1:0]  we;
      logic [31:0] blk0;
      logic [31:0] blk1;
      logic [31:0] adr0;
      logic [31:0] adr1;
      int          sup0;
      int          sup1;
      logic [1:0]  exp_first;
      logic [1:0]  exp_err;
      int          exp_b0;
      int          exp_b1;
   } vec_t;

   int n_cmp = 0;
   int n_fail = 0;
   int sup [2];
   bit mdl_abort = 1'b0;
   int ren_cnt = 0;
   int wen_cnt = 0;
   int ridx [2];
   int widx [2];
   int data_err = 0;
   int xviol = 0;
   bit ref_last = 1'b1;

   function automatic logic [7:0] rexp(int i);
      return 8'(i * 3 + 7);
   endfunction

   function automatic logic [7:0] wexp(int p, int i);
      return 8'(i) ^ ((p == 1) ? 8'hA5 : 8'h5A);
   endfunction

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", nm, act, exp);
      end
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "/ctl"}, {o_grant, o_done, o_err, o_rdata_en,
          o_wdata_ready, sd_ren, sd_wen, o_rdata, sd_wdata}, 64'd0);
      chk({nm, "/cmd"}, {sd_blk_num, sd_adr}, 64'd0);
   endtask

   // SD controller model: answers each strobe with a busy window
   initial begin : sd_model
      int p;
      int n;
      int i;
      bit rd;
      sd_ready = 1'b0;
      sd_rdata = 8'd0;
      sd_rdata_en = 1'b0;
      sd_wdata_ready = 1'b0;
      forever begin
         @(posedge i_clk);
         #1;
         if (sd_ren || sd_wen) begin
            p = o_grant[1] ? 1 : 0;
            rd = sd_ren;
            if (sd_ren) ren_cnt++;
            else wen_cnt++;
            n = sup[p];
            if (n >= 0) begin
               sd_ready = 1'b0;
               @(posedge i_clk);
               #1;
               i = 0;
               while (i < n && !mdl_abort) begin
                  @(posedge i_clk);
                  #1;
                  sd_rdata_en = 1'b0;
                  sd_wdata_ready = 1'b0;
                  if (!mdl_abort && $urandom_range(3) != 0) begin
                     if (rd) begin
                        sd_rdata = rexp(i);
                        sd_rdata_en = 1'b1;
                     end else begin
                        sd_wdata_ready = 1'b1;
                     end
                     i++;
                  end
               end
               @(posedge i_clk);
               #1;
               sd_rdata_en = 1'b0;
               sd_wdata_ready = 1'b0;
               if (!mdl_abort) sd_ready = 1'b1;
            end
         end
      end
   end

   // port-side monitor: checks routed data and supplies write bytes
   always @(negedge i_clk) begin
      for (int p = 0; p < 2; p++) begin
         if (o_rdata_en[p]) begin
            if (o_rdata !== rexp(ridx[p])) data_err++;
            ridx[p]++;
         end
         if (o_wdata_ready[p]) begin
            if (sd_wdata !== wexp(p, widx[p])) data_err++;
            widx[p]++;
         end
      end
      if (((o_rdata_en | o_wdata_ready) & ~o_grant) != 2'b00) xviol++;
      i_wdata0 = wexp(0, widx[0]);
      i_wdata1 = wexp(1, widx[1]);
   end

   task automatic run_vec(input vec_t v, input string nm);
      logic [1:0] pend;
      logic [1:0] first;
      logic [1:0] errs;
      int cyc;
      int r0;
      int w0;
      int er;
      int ew;
      @(posedge i_clk);
      #1;
      sup[0] = v.sup0;
      sup[1] = v.sup1;
      i_we = v.we;
      i_blk_num0 = v.blk0;
      i_blk_num1 = v.blk1;
      i_adr0 = v.adr0;
      i_adr1 = v.adr1;
      ridx[0] = 0; ridx[1] = 0;
      widx[0] = 0; widx[1] = 0;
      data_err = 0;
      xviol = 0;
      r0 = ren_cnt;
      w0 = wen_cnt;
      er = 0;
      ew = 0;
      if (v.req[0] && v.blk0 != 0) begin
         if (v.we[0]) ew++; else er++;
      end
      if (v.req[1] && v.blk1 != 0) begin
         if (v.we[1]) ew++; else er++;
      end
      i_req = v.req;
      pend = v.req;
      first = 2'b00;
      errs = 2'b00;
      cyc = 0;
      while (pend != 2'b00 && cyc < 8000) begin
         @(negedge i_clk);
         cyc++;
         if (o_done != 2'b00) begin
            if (first == 2'b00) first = o_done;
            chk({nm, "/grant_at_done"}, o_grant, o_done);
            if (o_done[0]) begin
               errs[0] = o_err;
               chk({nm, "/adr0"}, sd_adr, v.adr0);
               chk({nm, "/blk0"}, sd_blk_num, v.blk0);
            end
            if (o_done[1]) begin
               errs[1] = o_err;
               chk({nm, "/adr1"}, sd_adr, v.adr1);
               chk({nm, "/blk1"}, sd_blk_num, v.blk1);
            end
            pend = pend & ~o_done;
            i_req = i_req & ~o_done;
         end
      end
      if (pend != 2'b00) chk({nm, "/done_timeout"}, pend, 2'b00);
      i_req = 2'b00;
      repeat (3) @(negedge i_clk);
      chk({nm, "/first"}, first, v.exp_first);
      chk({nm, "/err"}, errs & v.req, v.exp_err & v.req);
      chk({nm, "/bytes0"}, ridx[0] + widx[0], v.exp_b0);
      chk({nm, "/bytes1"}, ridx[1] + widx[1], v.exp_b1);
      chk({nm, "/ren"}, ren_cnt - r0, er);
      chk({nm, "/wen"}, wen_cnt - w0, ew);
      chk({nm, "/data"}, data_err, 0);
      chk({nm, "/xport"}, xviol, 0);
   endtask

   vec_t tbl [7];

   initial begin : main
      int cyc;
      int r0;
      int w0;
      vec_t v;
      tbl[0] = '{req: 2'b11, we: 2'b10, blk0: 1, blk1: 2,
                 adr0: 32'h10, adr1: 32'h200, sup0: 512, sup1: 1024,
                 exp_first: 2'b01, exp_err: 2'b00,
                 exp_b0: 512, exp_b1: 1024};
      tbl[1] = '{req: 2'b10, we: 2'b00, blk0: 1, blk1: 0,
                 adr0: 32'h0, adr1: 32'h33, sup0: 512, sup1: 512,
                 exp_first: 2'b10, exp_err: 2'b10,
                 exp_b0: 0, exp_b1: 0};
      tbl[2] = '{req: 2'b10, we: 2'b00, blk0: 1, blk1: 1,
                 adr0: 32'h0, adr1: 32'h44, sup0: 512, sup1: -1,
                 exp_first: 2'b10, exp_err: 2'b10,
                 exp_b0: 0, exp_b1: 0};
      tbl[3] = '{req: 2'b01, we: 2'b00, blk0: 2, blk1: 1,
                 adr0: 32'h1234, adr1: 32'h0, sup0: 1000, sup1: 512,
                 exp_first: 2'b01, exp_err: 2'b01,
                 exp_b0: 1000, exp_b1: 0};
      tbl[4] = '{req: 2'b11, we: 2'b01, blk0: 1, blk1: 1,
                 adr0: 32'h55, adr1: 32'h66, sup0: 512, sup1: 512,
                 exp_first: 2'b10, exp_err: 2'b00,
                 exp_b0: 512, exp_b1: 512};
      tbl[5] = '{req: 2'b01, we: 2'b01, blk0: 1, blk1: 1,
                 adr0: 32'h77, adr1: 32'h0, sup0: 511, sup1: 512,
                 exp_first: 2'b01, exp_err: 2'b01,
                 exp_b0: 511, exp_b1: 0};
      tbl[6] = '{req: 2'b11, we: 2'b10, blk0: 0, blk1: 1,
                 adr0: 32'h88, adr1: 32'h99, sup0: 512, sup1: 512,
                 exp_first: 2'b10, exp_err: 2'b01,
                 exp_b0: 0, exp_b1: 512};
      sup[0] = 512;
      sup[1] = 512;
      ridx[0] = 0; ridx[1] = 0;
      widx[0] = 0; widx[1] = 0;

      repeat (3) @(negedge i_clk);
      i_rst_n = 1'b1;
      @(negedge i_clk);
      chk_zero("reset");
      @(posedge i_clk);
      #1;
      sd_ready = 1'b1;

      for (int k = 0; k < 7; k++) run_vec(tbl[k], $sformatf("vec%0d", k));

      // zero-block request finishes quickly without any command
      @(posedge i_clk);
      #1;
      r0 = ren_cnt;
      w0 = wen_cnt;
      i_we = 2'b00;
      i_blk_num1 = 32'd0;
      i_req = 2'b10;
      cyc = 0;
      while (o_done == 2'b00 && cyc < 20) begin
         @(negedge i_clk);
         cyc++;
      end
      chk("zero_latency_ok", cyc <= 3, 1);
      chk("zero_done", o_done, 2'b10);
      chk("zero_err", o_err, 1'b1);
      i_req = 2'b00;
      repeat (3) @(negedge i_clk);
      chk("zero_strobes", (ren_cnt - r0) + (wen_cnt - w0), 0);

      // controller never goes busy: timeout after the wait window
      @(posedge i_clk);
      #1;
      r0 = ren_cnt;
      sup[0] = -1;
      i_blk_num0 = 32'd1;
      i_req = 2'b01;
      cyc = 0;
      while (!sd_ren && cyc < 50) begin
         @(negedge i_clk);
         cyc++;
      end
      chk("tmo_strobe_seen", sd_ren, 1'b1);
      cyc = 0;
      while (o_done == 2'b00 && cyc < 200) begin
         @(negedge i_clk);
         cyc++;
      end
      chk("tmo_cycles", cyc, TMO + 1);
      chk("tmo_err", {o_done, o_err}, 3'b011);
      i_req = 2'b00;
      repeat (3) @(negedge i_clk);
      chk("tmo_one_strobe", ren_cnt - r0, 1);

      // reset in the middle of a read, then gated restart on sd_ready
      @(posedge i_clk);
      #1;
      sup[0] = 512;
      i_we = 2'b00;
      i_blk_num0 = 32'd1;
      i_adr0 = 32'h77;
      ridx[0] = 0;
      data_err = 0;
      i_req = 2'b01;
      cyc = 0;
      while (ridx[0] < 200 && cyc < 3000) begin
         @(negedge i_clk);
         cyc++;
      end
      chk("rst_reached_200", ridx[0] >= 200, 1);
      #2;
      i_rst_n = 1'b0;
      mdl_abort = 1'b1;
      #1;
      chk_zero("rst_async");
      repeat (4) @(negedge i_clk);
      sd_ready = 1'b0;
      i_rst_n = 1'b1;
      r0 = ren_cnt;
      repeat (10) @(negedge i_clk);
      chk("rst_no_grant", o_grant, 2'b00);
      chk("rst_no_strobe", ren_cnt - r0, 0);
      @(posedge i_clk);
      #1;
      mdl_abort = 1'b0;
      ridx[0] = 0;
      data_err = 0;
      sd_ready = 1'b1;
      cyc = 0;
      while (o_done == 2'b00 && cyc < 3000) begin
         @(negedge i_clk);
         cyc++;
      end
      chk("rst_resume_done", {o_done, o_err}, 3'b010);
      chk("rst_resume_adr", sd_adr, 32'h77);
      i_req = 2'b00;
      repeat (3) @(negedge i_clk);
      chk("rst_resume_bytes", ridx[0], 512);
      chk("rst_resume_data", data_err, 0);
      ref_last = 1'b0;

      // randomized transactions against the reference rules
      for (int t = 0; t < 12; t++) begin
         int blk [2];
         int sp [2];
         int mode;
         v.req = 2'($urandom_range(1, 3));
         v.we = 2'($urandom_range(0, 3));
         for (int p = 0; p < 2; p++) begin
            blk[p] = $urandom_range(0, 2);
            mode = $urandom_range(0, 5);
            sp[p] = blk[p] * BLK;
            if (mode == 4 && blk[p] > 0) sp[p] -= $urandom_range(1, 300);
            if (mode == 5) sp[p] = -1;
         end
         v.blk0 = blk[0];
         v.blk1 = blk[1];
         v.adr0 = $urandom;
         v.adr1 = $urandom;
         v.sup0 = sp[0];
         v.sup1 = sp[1];
         for (int p = 0; p < 2; p++) begin
            v.exp_err[p] = (blk[p] == 0) || (sp[p] < 0) || (sp[p] != blk[p] * BLK);
         end
         v.exp_b0 = (v.req[0] && blk[0] != 0 && sp[0] >= 0) ? sp[0] : 0;
         v.exp_b1 = (v.req[1] && blk[1] != 0 && sp[1] >= 0) ? sp[1] : 0;
         if (v.req == 2'b11) v.exp_first = ref_last ? 2'b01 : 2'b10;
         else v.exp_first = v.req;
         if (v.req != 2'b11) ref_last = v.req[1];
         run_vec(v, $sformatf("rnd%0d", t));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
